// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the moxie memory-access stage: access sizes, FSM states
// and the word-alignment helper used to form the bus address.
package cpu_memory_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_L = 2'b00,
    MEM_SIZE_S = 2'b01,
    MEM_SIZE_B = 2'b10,
    MEM_SIZE_X = 2'b11
  } mem_size_e;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_memory_lanes.sv
// Big-endian byte-lane steering: lane selects, replicated store data,
// zero-extended load data and misalignment detection for one access.
module cpu_memory_lanes
  import cpu_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_data,
  output logic [3:0]  sel,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data,
  output logic        misalign
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    sel         = 4'b1111;
    store_lanes = store_data;
    load_data   = bus_data;
    misalign    = 1'b0;
    case (mem_size_e'(size))
      MEM_SIZE_S: begin
        misalign    = addr_lo[0];
        sel         = addr_lo[1] ? 4'b0011 : 4'b1100;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {16'h0000, (addr_lo[1] ? bus_data[15:0] : bus_data[31:16])};
      end
      MEM_SIZE_B: begin
        sel         = 4'b1000 >> addr_lo;
        store_lanes = {4{store_data[7:0]}};
        case (addr_lo)
          2'd0:    load_data = {24'h000000, bus_data[31:24]};
          2'd1:    load_data = {24'h000000, bus_data[23:16]};
          2'd2:    load_data = {24'h000000, bus_data[15:8]};
          default: load_data = {24'h000000, bus_data[7:0]};
        endcase
      end
      // Long and the reserved encoding both behave as a full-word access.
      default: misalign = |addr_lo;
    endcase
  end

endmodule

// File: rtl/cpu_memory.sv
// Memory-access stage: forwards ALU write-backs, runs a classic Wishbone cycle
// for loads/stores and stalls upstream while that cycle is outstanding.
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        register_write_enable_i,
  input  logic [3:0]  register_write_index_i,
  input  logic [31:0] reg_result_i,
  input  logic        memory_read_enable_i,
  input  logic        memory_write_enable_i,
  input  logic [31:0] memory_address_i,
  input  logic [31:0] mem_result_i,
  input  logic [1:0]  mem_size_i,
  output logic        stall_o,
  output logic        register_write_enable_o,
  output logic [3:0]  register_write_index_o,
  output logic [31:0] reg_result_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  output logic        bus_error_o
);

  localparam int unsigned CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam bit TO_EN = (BUS_TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

  mem_state_e  state, state_next;
  logic [CW-1:0] count;
  logic [3:0]  cap_index;
  logic [31:0] cap_result;
  logic        cap_rwe, cap_write;
  logic [1:0]  cap_size, cap_addr_lo;

  logic [1:0]  lane_size, lane_addr;
  logic [3:0]  lane_sel;
  logic [31:0] lane_store, lane_load;
  logic        misalign, mem_req, timeout;

  assign mem_req = memory_read_enable_i | memory_write_enable_i;
  assign timeout = TO_EN && (count == TO_LAST);
  assign stall_o = (state == MEM_ACCESS);

  // While a cycle is outstanding the captured size/offset steer the returning load data.
  assign lane_size = stall_o ? cap_size    : mem_size_i;
  assign lane_addr = stall_o ? cap_addr_lo : memory_address_i[1:0];

  cpu_memory_lanes u_lanes (
    .size        (lane_size),
    .addr_lo     (lane_addr),
    .store_data  (mem_result_i),
    .bus_data    (dat_i),
    .sel         (lane_sel),
    .store_lanes (lane_store),
    .load_data   (lane_load),
    .misalign    (misalign)
  );

  always_comb begin
    state_next = state;
    case (state)
      MEM_IDLE:   if (mem_req && !misalign) state_next = MEM_ACCESS;
      MEM_ACCESS: if (ack_i || timeout)     state_next = MEM_IDLE;
      default:    state_next = MEM_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= MEM_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      register_write_enable_o <= 1'b0;
      register_write_index_o  <= '0;
      reg_result_o            <= '0;
      adr_o       <= '0;
      dat_o       <= '0;
      sel_o       <= '0;
      we_o        <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      bus_error_o <= 1'b0;
      count       <= '0;
      cap_index   <= '0;
      cap_result  <= '0;
      cap_rwe     <= 1'b0;
      cap_write   <= 1'b0;
      cap_size    <= '0;
      cap_addr_lo <= '0;
    end else begin
      bus_error_o <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (!mem_req) begin
            register_write_enable_o <= register_write_enable_i;
            register_write_index_o  <= register_write_index_i;
            reg_result_o            <= reg_result_i;
          end else if (misalign) begin
            register_write_enable_o <= 1'b0;
            bus_error_o             <= 1'b1;
          end else begin
            register_write_enable_o <= 1'b0;
            adr_o       <= word_align(memory_address_i);
            sel_o       <= lane_sel;
            dat_o       <= lane_store;
            we_o        <= memory_write_enable_i;
            cyc_o       <= 1'b1;
            stb_o       <= 1'b1;
            count       <= '0;
            cap_index   <= register_write_index_i;
            cap_result  <= reg_result_i;
            cap_rwe     <= register_write_enable_i;
            cap_write   <= memory_write_enable_i;
            cap_size    <= mem_size_i;
            cap_addr_lo <= memory_address_i[1:0];
          end
        end
        MEM_ACCESS: begin
          if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            // A store still retires its ALU result (e.g. the SP update of a push).
            register_write_enable_o <= cap_write ? cap_rwe : 1'b1;
            register_write_index_o  <= cap_index;
            reg_result_o            <= cap_write ? cap_result : lane_load;
          end else if (timeout) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            bus_error_o <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// Directed self-checking bench for cpu_memory: pass-through, loads, stores,
// lane steering, misalignment, bus timeout and reset during a bus cycle.
module tb_cpu_memory;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        register_write_enable_i;
  logic [3:0]  register_write_index_i;
  logic [31:0] reg_result_i;
  logic        memory_read_enable_i;
  logic        memory_write_enable_i;
  logic [31:0] memory_address_i;
  logic [31:0] mem_result_i;
  logic [1:0]  mem_size_i;
  logic        stall_o;
  logic        register_write_enable_o;
  logic [3:0]  register_write_index_o;
  logic [31:0] reg_result_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic        ack_i;
  logic        bus_error_o;

  int checks = 0;
  int failures = 0;
  int stall_cycles;

  cpu_memory #(.BUS_TIMEOUT(16)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .register_write_enable_i (register_write_enable_i),
    .register_write_index_i  (register_write_index_i),
    .reg_result_i            (reg_result_i),
    .memory_read_enable_i    (memory_read_enable_i),
    .memory_write_enable_i   (memory_write_enable_i),
    .memory_address_i        (memory_address_i),
    .mem_result_i            (mem_result_i),
    .mem_size_i              (mem_size_i),
    .stall_o                 (stall_o),
    .register_write_enable_o (register_write_enable_o),
    .register_write_index_o  (register_write_index_o),
    .reg_result_o            (reg_result_o),
    .adr_o                   (adr_o),
    .dat_o                   (dat_o),
    .dat_i                   (dat_i),
    .sel_o                   (sel_o),
    .we_o                    (we_o),
    .cyc_o                   (cyc_o),
    .stb_o                   (stb_o),
    .ack_i                   (ack_i),
    .bus_error_o             (bus_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    register_write_enable_i = 1'b0;
    register_write_index_i  = 4'd0;
    reg_result_i            = 32'h0;
    memory_read_enable_i    = 1'b0;
    memory_write_enable_i   = 1'b0;
    memory_address_i        = 32'h0;
    mem_result_i            = 32'h0;
    mem_size_i              = 2'b00;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rwe, input logic [3:0] idx, input logic [31:0] res);
    memory_read_enable_i    = rd;
    memory_write_enable_i   = wr;
    mem_size_i              = size;
    memory_address_i        = addr;
    mem_result_i            = wdata;
    register_write_enable_i = rwe;
    register_write_index_i  = idx;
    reg_result_i            = res;
  endtask

  initial begin
    rst_i = 1'b1;
    ack_i = 1'b0;
    dat_i = 32'h0;
    drive_idle();
    repeat (2) tick();

    check("rst_stall", stall_o, 0);
    check("rst_rwe",   register_write_enable_o, 0);
    check("rst_cyc",   cyc_o, 0);
    check("rst_stb",   stb_o, 0);
    check("rst_we",    we_o, 0);
    check("rst_err",   bus_error_o, 0);
    check("rst_sel",   sel_o, 0);
    check("rst_adr",   adr_o, 0);
    check("rst_dat",   dat_o, 0);
    check("rst_idx",   register_write_index_o, 0);
    check("rst_res",   reg_result_o, 0);
    rst_i = 1'b0;

    // ALU pass-through
    drive_mem(0, 0, 2'b00, 32'h0, 32'h0, 1, 4'd3, 32'h1234_5678);
    check("pt_stall_pre", stall_o, 0);
    tick();
    check("pt_rwe",   register_write_enable_o, 1);
    check("pt_idx",   register_write_index_o, 3);
    check("pt_res",   reg_result_o, 32'h1234_5678);
    check("pt_stall", stall_o, 0);
    drive_idle();
    tick();
    check("pt_rwe_off", register_write_enable_o, 0);

    // Long load at 0x1000, three wait cycles then ack
    drive_mem(1, 0, 2'b00, 32'h1000, 32'h0, 1, 4'd5, 32'h0);
    tick();
    drive_idle();
    check("ll_adr", adr_o, 32'h1000);
    check("ll_sel", sel_o, 4'b1111);
    check("ll_cyc", cyc_o, 1);
    check("ll_stb", stb_o, 1);
    check("ll_we",  we_o, 0);
    check("ll_rwe_issue", register_write_enable_o, 0);
    stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall_o) stall_cycles++;
      tick();
    end
    if (stall_o) stall_cycles++;
    ack_i = 1'b1;
    dat_i = 32'hDEAD_BEEF;
    tick();
    ack_i = 1'b0;
    check("ll_stall_cycles", stall_cycles, 4);
    check("ll_stall_after", stall_o, 0);
    check("ll_cyc_after", cyc_o, 0);
    check("ll_rwe", register_write_enable_o, 1);
    check("ll_idx", register_write_index_o, 5);
    check("ll_res", reg_result_o, 32'hDEAD_BEEF);

    // Byte load at 0x1003
    drive_mem(1, 0, 2'b10, 32'h1003, 32'h0, 1, 4'd6, 32'h0);
    tick();
    drive_idle();
    check("bl_sel", sel_o, 4'b0001);
    check("bl_adr", adr_o, 32'h1000);
    ack_i = 1'b1;
    dat_i = 32'hAABB_CCDD;
    tick();
    ack_i = 1'b0;
    check("bl_rwe", register_write_enable_o, 1);
    check("bl_idx", register_write_index_o, 6);
    check("bl_res", reg_result_o, 32'h0000_00DD);

    // Short load at 0x1002 takes the low halfword
    drive_mem(1, 0, 2'b01, 32'h1002, 32'h0, 1, 4'd2, 32'h0);
    tick();
    drive_idle();
    check("sl_sel", sel_o, 4'b0011);
    ack_i = 1'b1;
    dat_i = 32'h1122_3344;
    tick();
    ack_i = 1'b0;
    check("sl_res", reg_result_o, 32'h0000_3344);

    // Byte store 0x5A at 0x1001 with read also set: write wins
    drive_mem(1, 1, 2'b10, 32'h1001, 32'h1234_565A, 0, 4'd4, 32'h0);
    tick();
    drive_idle();
    check("bs_sel", sel_o, 4'b0100);
    check("bs_dat", dat_o, 32'h5A5A_5A5A);
    check("bs_we",  we_o, 1);
    check("bs_adr", adr_o, 32'h1000);
    ack_i = 1'b1;
    dat_i = 32'hFFFF_FFFF;
    tick();
    ack_i = 1'b0;
    check("bs_we_drop", we_o, 0);
    check("bs_no_wb", register_write_enable_o, 0);

    // Push-style store with SP write-back
    drive_mem(0, 1, 2'b00, 32'h0FFC, 32'h77, 1, 4'd1, 32'h0FFC);
    tick();
    drive_idle();
    check("ps_adr", adr_o, 32'h0FFC);
    check("ps_sel", sel_o, 4'b1111);
    check("ps_dat", dat_o, 32'h77);
    check("ps_we",  we_o, 1);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check("ps_rwe", register_write_enable_o, 1);
    check("ps_idx", register_write_index_o, 1);
    check("ps_res", reg_result_o, 32'h0FFC);

    // Misaligned long access
    drive_mem(1, 0, 2'b00, 32'h1002, 32'h0, 1, 4'd7, 32'h0);
    tick();
    drive_idle();
    check("ma_err",   bus_error_o, 1);
    check("ma_cyc",   cyc_o, 0);
    check("ma_stall", stall_o, 0);
    check("ma_rwe",   register_write_enable_o, 0);
    tick();
    check("ma_err_pulse", bus_error_o, 0);

    // Timeout: ack withheld for 16 cycles
    drive_mem(1, 0, 2'b00, 32'h2000, 32'h0, 1, 4'd8, 32'h0);
    tick();
    drive_idle();
    stall_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (stall_o) stall_cycles++;
      tick();
    end
    check("to_stall_cycles", stall_cycles, 16);
    check("to_err",   bus_error_o, 1);
    check("to_cyc",   cyc_o, 0);
    check("to_stall", stall_o, 0);
    check("to_rwe",   register_write_enable_o, 0);
    tick();
    check("to_err_pulse", bus_error_o, 0);

    // ack on cycle 16 beats the timeout
    drive_mem(1, 0, 2'b00, 32'h2000, 32'h0, 1, 4'd9, 32'h0);
    tick();
    drive_idle();
    for (int i = 0; i < 15; i++) tick();
    check("a16_stall", stall_o, 1);
    ack_i = 1'b1;
    dat_i = 32'hCAFE_F00D;
    tick();
    ack_i = 1'b0;
    check("a16_err", bus_error_o, 0);
    check("a16_rwe", register_write_enable_o, 1);
    check("a16_res", reg_result_o, 32'hCAFE_F00D);

    // Reset two cycles into a load, then a stray ack in IDLE
    drive_mem(1, 0, 2'b00, 32'h3000, 32'h0, 1, 4'd10, 32'h0);
    tick();
    drive_idle();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rs_cyc",   cyc_o, 0);
    check("rs_stb",   stb_o, 0);
    check("rs_stall", stall_o, 0);
    check("rs_rwe",   register_write_enable_o, 0);
    ack_i = 1'b1;
    dat_i = 32'h5555_5555;
    tick();
    ack_i = 1'b0;
    check("idle_ack_rwe", register_write_enable_o, 0);
    check("idle_ack_cyc", cyc_o, 0);
    check("idle_ack_res", reg_result_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
